// File: rtl/vga_lane_scorer_pkg.sv
// Shared colour constants, coordinate width and the palette reset image
// for the VGA lane scorer.
package vga_lane_scorer_pkg;

  localparam int YW = 10;

  typedef logic [11:0] rgb444_t;

  localparam rgb444_t BLACK = 12'h000;
  localparam rgb444_t GREEN = 12'h0F0;
  localparam rgb444_t RED   = 12'hF00;
  localparam rgb444_t BGCLR = 12'hEEE;

  function automatic rgb444_t default_pal(input int idx);
    case (idx)
      2:       return 12'hFA5;
      3:       return 12'hF69;
      4:       return 12'hB48;
      5:       return 12'h8BE;
      6:       return 12'h45A;
      7:       return 12'h437;
      8:       return BLACK;
      9:       return 12'hDCF;
      default: return BGCLR;
    endcase
  endfunction

endpackage

// File: rtl/vga_lane_scorer_lane.sv
// One rhythm lane: falling target Y, button synchroniser with edge detect,
// arm/lock state and the hit-window compare.
module vga_lane_scorer_lane
  import vga_lane_scorer_pkg::*;
#(
  parameter int IDX          = 0,
  parameter int Y_WRAP       = 779,
  parameter int LANE_STAGGER = 195,
  parameter int HIT_LO       = 400,
  parameter int HIT_HI       = 475,
  parameter int REARM_Y      = 20
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          tick,
  input  logic          button,
  output logic          hit,
  output logic          miss,
  output logic          armed,
  output logic [YW-1:0] y
);

  localparam logic [YW-1:0] Y_INIT  = YW'((IDX * LANE_STAGGER) % (Y_WRAP + 1));
  localparam logic [YW-1:0] WRAP_V  = YW'(Y_WRAP);
  localparam logic [YW-1:0] LO_V    = YW'(HIT_LO);
  localparam logic [YW-1:0] HI_V    = YW'(HIT_HI);
  localparam logic [YW-1:0] REARM_V = YW'(REARM_Y);

  logic          s1_q, s1_d;
  logic          s2_q, s2_d;
  logic          prev_q, prev_d;
  logic          armed_q, armed_d;
  logic [YW-1:0] y_q, y_d;
  logic          rise;
  logic          in_win;

  always_comb begin
    s1_d   = button;
    s2_d   = s1_q;
    prev_d = s2_q;
    rise   = s2_q & ~prev_q;
    // Window uses the current Y, so a coincident tick sees the pre-step value.
    in_win = (y_q >= LO_V) && (y_q <= HI_V);
    hit    = rise & armed_q & in_win;
    miss   = rise & armed_q & ~in_win;

    armed_d = armed_q;
    if (hit)
      armed_d = 1'b0;
    else if (y_q <= REARM_V)
      armed_d = 1'b1;

    y_d = y_q;
    if (tick)
      y_d = (y_q == WRAP_V) ? '0 : y_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      prev_q  <= 1'b0;
      armed_q <= 1'b1;
      y_q     <= Y_INIT;
    end else begin
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      prev_q  <= prev_d;
      armed_q <= armed_d;
      y_q     <= y_d;
    end
  end

  assign armed = armed_q;
  assign y     = y_q;

endmodule

// File: rtl/vga_lane_scorer.sv
// Pixel colour stage with writable palette, falling-target overlay and
// saturating lane score; rgb is registered straight to the VGA pins.
module vga_lane_scorer
  import vga_lane_scorer_pkg::*;
#(
  parameter int CIDXW        = 3,
  parameter int NLANES       = 4,
  parameter int TICK_DIV     = 500000,
  parameter int Y_WRAP       = 779,
  parameter int LANE_STAGGER = 195,
  parameter int HIT_LO       = 400,
  parameter int HIT_HI       = 475,
  parameter int REARM_Y      = 20,
  parameter int LANE_X0      = 340,
  parameter int LANE_PITCH   = 80,
  parameter int SQ_W         = 40,
  parameter int SQ_H         = 40,
  parameter int MISS_PENALTY = 0,
  parameter int SCOREW       = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              bright,
  input  logic [9:0]        hCount,
  input  logic [9:0]        vCount,
  input  logic [CIDXW:0]    pix,
  input  logic [NLANES-1:0] button,
  input  logic              pal_we,
  input  logic [CIDXW:0]    pal_addr,
  input  logic [11:0]       pal_data,
  output logic [11:0]       rgb,
  output logic [SCOREW-1:0] score,
  output logic [NLANES-1:0] hit_pulse,
  output logic [NLANES-1:0] miss_pulse
);

  localparam int PDEPTH = 2 ** (CIDXW + 1);
  localparam int DIVW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SW     = SCOREW + 4;
  localparam logic [DIVW-1:0]     DIV_LAST = DIVW'(TICK_DIV - 1);
  localparam logic signed [SW-1:0] ONE     = SW'(1);
  localparam logic signed [SW-1:0] MAXV    = $signed({4'b0000, {SCOREW{1'b1}}});

  logic [DIVW-1:0]     div_q, div_d;
  logic                tick;
  rgb444_t             pal_q [PDEPTH];
  rgb444_t             pal_d [PDEPTH];
  rgb444_t             rgb_q, rgb_d;
  logic [SCOREW-1:0]   score_q, score_d;
  logic [NLANES-1:0]   hit_pulse_q, hit_pulse_d;
  logic [NLANES-1:0]   miss_pulse_q, miss_pulse_d;
  logic [NLANES-1:0]   lane_hit, lane_miss, lane_armed, in_tgt;
  logic [YW-1:0]       lane_y [NLANES];
  logic signed [SW-1:0] acc;

  assign tick = (div_q == DIV_LAST);

  for (genvar g = 0; g < NLANES; g++) begin : g_lane
    localparam logic [10:0] XL = 11'(LANE_X0 + g * LANE_PITCH);
    localparam logic [10:0] XH = 11'(LANE_X0 + g * LANE_PITCH + SQ_W);

    vga_lane_scorer_lane #(
      .IDX          (g),
      .Y_WRAP       (Y_WRAP),
      .LANE_STAGGER (LANE_STAGGER),
      .HIT_LO       (HIT_LO),
      .HIT_HI       (HIT_HI),
      .REARM_Y      (REARM_Y)
    ) u_lane (
      .clk    (clk),
      .rst    (reset),
      .tick   (tick),
      .button (button[g]),
      .hit    (lane_hit[g]),
      .miss   (lane_miss[g]),
      .armed  (lane_armed[g]),
      .y      (lane_y[g])
    );

    // Bottom edge is computed one bit wider so targets near the wrap point never alias.
    assign in_tgt[g] = ({1'b0, hCount} >= XL) && ({1'b0, hCount} < XH) &&
                       (vCount >= lane_y[g]) &&
                       ({1'b0, vCount} <= ({1'b0, lane_y[g]} + 11'(SQ_H)));
  end

  always_comb begin
    div_d = tick ? '0 : div_q + 1'b1;

    pal_d = pal_q;
    if (pal_we)
      pal_d[pal_addr] = pal_data;

    rgb_d = pal_q[pix];
    for (int i = NLANES - 1; i >= 0; i--) begin
      if (in_tgt[i])
        rgb_d = lane_armed[i] ? GREEN : RED;
    end
    if (!bright)
      rgb_d = BLACK;

    acc = $signed({4'b0000, score_q});
    for (int i = 0; i < NLANES; i++) begin
      if (lane_hit[i])
        acc = acc + ONE;
      if ((MISS_PENALTY != 0) && lane_miss[i])
        acc = acc - ONE;
    end
    if (acc < 0)
      score_d = '0;
    else if (acc > MAXV)
      score_d = '1;
    else
      score_d = acc[SCOREW-1:0];

    hit_pulse_d  = lane_hit;
    miss_pulse_d = lane_miss;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_q        <= '0;
      rgb_q        <= BLACK;
      score_q      <= '0;
      hit_pulse_q  <= '0;
      miss_pulse_q <= '0;
      for (int i = 0; i < PDEPTH; i++)
        pal_q[i] <= default_pal(i);
    end else begin
      div_q        <= div_d;
      rgb_q        <= rgb_d;
      score_q      <= score_d;
      hit_pulse_q  <= hit_pulse_d;
      miss_pulse_q <= miss_pulse_d;
      pal_q        <= pal_d;
    end
  end

  assign rgb        = rgb_q;
  assign score      = score_q;
  assign hit_pulse  = hit_pulse_q;
  assign miss_pulse = miss_pulse_q;

endmodule

// File: tb/tb_vga_lane_scorer.sv
// Directed bench for vga_lane_scorer: A = default lanes, B = stacked lanes
// with miss penalty and overlapping targets, C = 2-bit score for saturation.
module tb_vga_lane_scorer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        bright = 1'b1;
  logic [9:0]  hc = 10'd0;
  logic [9:0]  vc = 10'd500;
  logic [3:0]  pix = 4'd2;
  logic        pal_we = 1'b0;
  logic [3:0]  pal_addr = 4'd0;
  logic [11:0] pal_data = 12'h000;
  logic [3:0]  btn_a = '0, btn_b = '0, btn_c = '0;
  logic [11:0] rgb_a, rgb_b, rgb_c;
  logic [15:0] score_a, score_b;
  logic [1:0]  score_c;
  logic [3:0]  hit_a, hit_b, hit_c, miss_a, miss_b, miss_c;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  // Edges since reset release; lane Y = (init + cyc/4) mod 780 with TICK_DIV=4.
  always @(posedge clk or posedge rst)
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;

  vga_lane_scorer #(.TICK_DIV(4)) u_a (
    .clk(clk), .reset(rst), .bright(bright), .hCount(hc), .vCount(vc), .pix(pix),
    .button(btn_a), .pal_we(pal_we), .pal_addr(pal_addr), .pal_data(pal_data),
    .rgb(rgb_a), .score(score_a), .hit_pulse(hit_a), .miss_pulse(miss_a));

  vga_lane_scorer #(.TICK_DIV(4), .LANE_STAGGER(0), .LANE_PITCH(20), .MISS_PENALTY(1)) u_b (
    .clk(clk), .reset(rst), .bright(bright), .hCount(hc), .vCount(vc), .pix(pix),
    .button(btn_b), .pal_we(pal_we), .pal_addr(pal_addr), .pal_data(pal_data),
    .rgb(rgb_b), .score(score_b), .hit_pulse(hit_b), .miss_pulse(miss_b));

  vga_lane_scorer #(.TICK_DIV(4), .LANE_STAGGER(0), .SCOREW(2)) u_c (
    .clk(clk), .reset(rst), .bright(bright), .hCount(hc), .vCount(vc), .pix(pix),
    .button(btn_c), .pal_we(pal_we), .pal_addr(pal_addr), .pal_data(pal_data),
    .rgb(rgb_c), .score(score_c), .hit_pulse(hit_c), .miss_pulse(miss_c));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_cyc(input int c);
    int guard = 0;
    while (cyc < c && guard < 10000) begin
      @(negedge clk);
      guard++;
    end
    if (cyc != c) chk("schedule", 32'(cyc), 32'(c));
  endtask

  task automatic set_btn(input int inst, input logic [3:0] m);
    case (inst)
      0: btn_a = m;
      1: btn_b = m;
      default: btn_c = m;
    endcase
  endtask

  function automatic logic [31:0] obs_hit(input int inst);
    case (inst)
      0: return 32'(hit_a);
      1: return 32'(hit_b);
      default: return 32'(hit_c);
    endcase
  endfunction

  function automatic logic [31:0] obs_miss(input int inst);
    case (inst)
      0: return 32'(miss_a);
      1: return 32'(miss_b);
      default: return 32'(miss_c);
    endcase
  endfunction

  function automatic logic [31:0] obs_score(input int inst);
    case (inst)
      0: return 32'(score_a);
      1: return 32'(score_b);
      default: return 32'(score_c);
    endcase
  endfunction

  // One-cycle press at cycle c; pulses/score are due two edges after the sampling edge.
  task automatic press(input string tag, input int c, input int inst, input logic [3:0] m,
                       input logic [3:0] ehit, input logic [3:0] emiss, input logic [15:0] escore);
    wait_cyc(c);
    set_btn(inst, m);
    @(negedge clk);
    set_btn(inst, 4'b0);
    @(negedge clk);
    @(negedge clk);
    chk({tag, ".hit"}, obs_hit(inst), 32'(ehit));
    chk({tag, ".miss"}, obs_miss(inst), 32'(emiss));
    chk({tag, ".score"}, obs_score(inst), 32'(escore));
    @(negedge clk);
    chk({tag, ".hit_off"}, obs_hit(inst), 32'd0);
    chk({tag, ".miss_off"}, obs_miss(inst), 32'd0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst.rgb", 32'(rgb_a), 32'h000);
    chk("rst.score", 32'(score_a), 32'd0);
    chk("rst.hit", 32'(hit_a), 32'd0);
    chk("rst.miss", 32'(miss_a), 32'd0);
    chk("rst.score_b", 32'(score_b), 32'd0);

    hc = 10'd350; vc = 10'd40;
    rst = 1'b0;
    @(negedge clk); chk("tgt.bottom_in", 32'(rgb_a), 32'h0F0);
    vc = 10'd41;
    @(negedge clk); chk("tgt.bottom_out", 32'(rgb_a), 32'hFA5);
    hc = 10'd379; vc = 10'd0;
    @(negedge clk); chk("tgt.right_in", 32'(rgb_a), 32'h0F0);
    hc = 10'd380;
    @(negedge clk); chk("tgt.right_out", 32'(rgb_a), 32'hFA5);
    hc = 10'd0; vc = 10'd500; pix = 4'd9;
    @(negedge clk); chk("pal.9", 32'(rgb_a), 32'hDCF);
    pix = 4'd5;
    @(negedge clk); chk("pal.5", 32'(rgb_a), 32'h8BE);
    pix = 4'd15;
    @(negedge clk); chk("pal.15", 32'(rgb_a), 32'hEEE);
    pix = 4'd2; pal_we = 1'b1; pal_addr = 4'd2; pal_data = 12'h123;
    @(negedge clk); chk("pal.old_on_write", 32'(rgb_a), 32'hFA5);
    pal_we = 1'b0;
    @(negedge clk); chk("pal.new", 32'(rgb_a), 32'h123);
    bright = 1'b0;
    @(negedge clk); chk("blank", 32'(rgb_a), 32'h000);
    bright = 1'b1;

    press("a.l2_y476", 342, 0, 4'b0100, 4'b0000, 4'b0100, 16'd0);
    press("b.l1_miss0", 400, 1, 4'b0010, 4'b0000, 4'b0010, 16'd0);
    press("a.l1_y475_tick", 1121, 0, 4'b0010, 4'b0010, 4'b0000, 16'd1);
    press("a.l0_y400", 1598, 0, 4'b0001, 4'b0001, 4'b0000, 16'd2);
    press("b.triple", 1620, 1, 4'b0111, 4'b0111, 4'b0000, 16'd3);

    wait_cyc(1630);
    hc = 10'd410; vc = 10'd412;
    @(negedge clk); chk("b.lowest_lane_red", 32'(rgb_b), 32'hF00);
    hc = 10'd430;
    @(negedge clk); chk("b.lane3_green", 32'(rgb_b), 32'h0F0);
    hc = 10'd0; vc = 10'd500;

    press("a.l0_locked", 1638, 0, 4'b0001, 4'b0000, 4'b0000, 16'd2);
    press("b.l3_hit", 1650, 1, 4'b1000, 4'b1000, 4'b0000, 16'd4);
    press("c.l0", 1660, 2, 4'b0001, 4'b0001, 4'b0000, 16'd1);
    press("c.l1", 1670, 2, 4'b0010, 4'b0010, 4'b0000, 16'd2);
    press("c.sat", 1680, 2, 4'b1100, 4'b1100, 4'b0000, 16'd3);
    press("a.l3_y399", 2374, 0, 4'b1000, 4'b0000, 4'b1000, 16'd2);
    press("a.l3_y400", 2378, 0, 4'b1000, 4'b1000, 4'b0000, 16'd3);

    wait_cyc(3100);
    hc = 10'd350; vc = 10'd780;
    @(negedge clk); chk("a.locked_red", 32'(rgb_a), 32'hF00);
    wait_cyc(3130);
    vc = 10'd7;
    @(negedge clk); chk("a.rearmed_green", 32'(rgb_a), 32'h0F0);
    hc = 10'd0; vc = 10'd500;

    press("b.miss_dec", 3400, 1, 4'b0010, 4'b0000, 4'b0010, 16'd3);

    wait_cyc(3410);
    pix = 4'd2;
    @(negedge clk);
    chk("pre_rst.rgb", 32'(rgb_a), 32'h123);
    chk("pre_rst.score", 32'(score_a), 32'd3);
    btn_a = 4'b0100;
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async_rst.rgb", 32'(rgb_a), 32'h000);
    chk("async_rst.score", 32'(score_a), 32'd0);
    chk("async_rst.hit", 32'(hit_a), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk); chk("post_rst.pal_default", 32'(rgb_a), 32'hFA5);
    wait_cyc(60);
    chk("held_no_score", 32'(score_a), 32'd0);
    btn_a = 4'b0000;
    press("a.fresh_press", 70, 0, 4'b0100, 4'b0100, 4'b0000, 16'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
